// File: rtl/wb_init_pkg.sv
// Shared types and helpers for the Wishbone command initiator.
// Holds the FSM state encoding, bus width defaults and the timeout counter width.
package wb_init_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int SEL_W = WB_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Counter runs 0..cycles-1, so it needs clog2(cycles) bits (at least 1).
    function automatic int to_width(input int cycles);
        return (cycles < 3) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, registered full/empty, no bypass.
// Ports: clk, reset (sync, high), push/wdata, pop/rdata, full, empty.
module wb_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wptr_q;
    logic [PW:0]  rptr_q;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign rdata = mem_q[rptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator: queued {we,sel,adr,dat} commands in,
// one WB cycle per command, read data/status out on a valid/ready response port.
// Ports: cmd_* (command in), rsp_* (response out), wbm_* (WB master), busy.
// Optional ack timeout enabled by defining WB_INIT_TIMEOUT_EN.
module wb_cmd_initiator
    import wb_init_pkg::*;
#(
    parameter int AW             = WB_AW,
    parameter int DW             = WB_DW,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    output logic            busy
);

    localparam int SW = DW / 8;
    localparam int FW = 1 + SW + AW + DW;

    logic [FW-1:0] f_wdata;
    logic [FW-1:0] f_rdata;
    logic          f_full;
    logic          f_empty;
    logic          f_pop;

    assign f_wdata   = {cmd_we, cmd_sel, cmd_adr, cmd_dat};
    assign cmd_ready = !f_full;

    wb_cmd_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid & cmd_ready),
        .pop   (f_pop),
        .wdata (f_wdata),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    wb_state_e       state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            rv_q, rv_d;
    logic [DW-1:0]   rdat_q, rdat_d;

`ifdef WB_INIT_TIMEOUT_EN
    localparam int TW = to_width(TIMEOUT_CYCLES);
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            rerr_q, rerr_d;
    assign rsp_err = rerr_q;
`else
    logic            unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        f_pop   = 1'b0;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rv_d    = rv_q;
        rdat_d  = rdat_q;
`ifdef WB_INIT_TIMEOUT_EN
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!f_empty) begin
                    f_pop = 1'b1;
                    {we_d, sel_d, adr_d, dat_d} = f_rdata;
                    cyc_d   = 1'b1;
                    state_d = REQ;
`ifdef WB_INIT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    {cyc_d, we_d, sel_d, adr_d, dat_d} = '0;
                    rv_d    = 1'b1;
                    rdat_d  = we_q ? '0 : wbm_dat_i;
                    state_d = RESP;
`ifdef WB_INIT_TIMEOUT_EN
                    rerr_d  = 1'b0;
                end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    {cyc_d, we_d, sel_d, adr_d, dat_d} = '0;
                    rv_d    = 1'b1;
                    rdat_d  = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    rdat_d  = '0;
                    state_d = IDLE;
`ifdef WB_INIT_TIMEOUT_EN
                    rerr_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rv_q    <= 1'b0;
            rdat_q  <= '0;
`ifdef WB_INIT_TIMEOUT_EN
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
`ifdef WB_INIT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            rerr_q  <= rerr_d;
`endif
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rv_q;
    assign rsp_dat   = rdat_q;
    assign busy      = (state_q != IDLE) || !f_empty;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Scoreboard bench for wb_cmd_initiator with a memory-backed WB slave model.
// Expected bus transfers and responses are queued at command acceptance.
module tb_wb_cmd_initiator;
    import wb_init_pkg::*;

    localparam int AW = WB_AW;
    localparam int DW = WB_DW;
    localparam int SW = SEL_W;
    localparam int TO = 8;

    logic          clk = 0;
    logic          reset = 1;
    logic          cmd_valid = 0;
    logic          cmd_ready;
    logic          cmd_we = 0;
    logic [SW-1:0] cmd_sel = '0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          busy;

    wb_cmd_initiator #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_sel(cmd_sel),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [SW-1:0] sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } xfer_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    xfer_t wbq[$];
    rsp_t  rspq[$];
    logic [DW-1:0] mmem [logic [AW-1:0]];
    logic [DW-1:0] smem [logic [AW-1:0]];

    int checks = 0;
    int failures = 0;

    bit mon_en = 0;
    bit ack_en = 1;
    bit force_ack = 0;
    int dly_min = 0;
    int dly_max = 1;
    int rdy_mode = 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++)
            if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Reference model: commands complete in order, reads see prior writes.
    function automatic void model_cmd(input xfer_t x, input bit to_err);
        rsp_t r;
        logic [DW-1:0] cur;
        cur = mmem.exists(x.adr) ? mmem[x.adr] : init_val(x.adr);
        r.err = to_err;
        if (to_err) r.dat = '0;
        else if (x.we) begin
            mmem[x.adr] = merge(cur, x.dat, x.sel);
            r.dat = '0;
        end else r.dat = cur;
        wbq.push_back(x);
        rspq.push_back(r);
    endfunction

    task automatic push(input bit we, input logic [SW-1:0] sel,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input bit to_err);
        xfer_t x;
        bit ok;
        ok = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk);
            cmd_valid = 1; cmd_we = we; cmd_sel = sel;
            cmd_adr = adr; cmd_dat = dat;
            if (cmd_ready) ok = 1;
        end
        if (!ok) chk("push_timeout", 0, 1);
        @(posedge clk);
        if (ok) begin
            x.we = we; x.sel = sel; x.adr = adr; x.dat = dat;
            model_cmd(x, to_err);
        end
        #1 cmd_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rspq.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (n < 1000), 1);
    endtask

    // Slave: memory-backed, ack after a random number of wait cycles.
    int s_wait = 0;
    int s_dly = 0;
    initial begin
        wbm_ack_i = 0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                wbm_ack_i = 1;
                wbm_dat_i = $urandom;
            end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
                if (s_wait >= s_dly) begin
                    wbm_ack_i = 1;
                    if (!smem.exists(wbm_adr_o))
                        smem[wbm_adr_o] = init_val(wbm_adr_o);
                    if (wbm_we_o) begin
                        smem[wbm_adr_o] = merge(smem[wbm_adr_o],
                                                wbm_dat_o, wbm_sel_o);
                        wbm_dat_i = $urandom;
                    end else wbm_dat_i = smem[wbm_adr_o];
                    s_wait = 0;
                end else begin
                    s_wait++;
                    wbm_ack_i = 0;
                    wbm_dat_i = $urandom;
                end
            end else begin
                wbm_ack_i = 0;
                wbm_dat_i = $urandom;
                if (!wbm_cyc_o) begin
                    s_wait = 0;
                    s_dly = $urandom_range(dly_min, dly_max);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: rsp_ready = 0;
            1: rsp_ready = 1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Bus monitor: transfer order, stability, idle zeros, ack->rsp latency.
    bit    prev_cyc = 0;
    bit    prev_ack = 0;
    xfer_t cur;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_cyc = 0;
            prev_ack = 0;
        end else begin
            chk("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
            if (prev_ack) begin
                chk("rsp_after_ack", rsp_valid, 1);
                chk("cyc_drop_after_ack", wbm_cyc_o, 0);
            end
            if (!wbm_cyc_o) begin
                chk("idle_zero", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
            end else if (!prev_cyc) begin
                if (wbq.size() == 0) chk("unexpected_cyc", 1, 0);
                else begin
                    cur = wbq.pop_front();
                    chk("xfer_we", wbm_we_o, cur.we);
                    chk("xfer_sel", wbm_sel_o, cur.sel);
                    chk("xfer_adr", wbm_adr_o, cur.adr);
                    if (cur.we) chk("xfer_dat", wbm_dat_o, cur.dat);
                end
            end else begin
                chk("hold", {wbm_we_o, wbm_sel_o, wbm_adr_o},
                    {cur.we, cur.sel, cur.adr});
            end
            prev_ack = wbm_cyc_o && wbm_ack_i;
            prev_cyc = wbm_cyc_o;
        end
    end

    // Response monitor.
    rsp_t er;
    always @(negedge clk) begin
        if (mon_en && rsp_valid && rsp_ready) begin
            if (rspq.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                er = rspq.pop_front();
                chk("rsp_dat", rsp_dat, er.dat);
                chk("rsp_err", rsp_err, er.err);
            end
        end
    end

    initial begin
        bit seen;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_outs", {rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, busy}, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        mon_en = 1;

        // Directed write with 1-cycle ack, and stb latency N+2.
        dly_min = 1; dly_max = 1;
        push(1, 4'hF, 32'h3000_0000, 32'h0001_0002, 0);
        @(negedge clk);
        chk("lat_n1_stb", wbm_stb_o, 0);
        @(negedge clk);
        chk("lat_n2_stb", wbm_stb_o, 1);
        chk("wr_we", wbm_we_o, 1);
        drain();

        // Directed read of a known word.
        smem[32'h3000_0004] = 32'h0000_0003;
        mmem[32'h3000_0004] = 32'h0000_0003;
        push(0, 4'hF, 32'h3000_0004, 32'h0, 0);
        drain();

        // Queue fill with ack stalled: 1 in flight + 4 stored.
        ack_en = 0; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 5; i++)
            push(1, 4'hF, 32'h3000_0010 + 4 * i, 32'h100 + i, 0);
        @(negedge clk);
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0040;
        chk("full_busy", busy, 1);
        repeat (2) begin
            chk("full_not_ready", cmd_ready, 0);
            @(negedge clk);
        end
        chk("full_not_ready", cmd_ready, 0);
        cmd_valid = 0;
        ack_en = 1;
        for (int i = 0; i < 5; i++)
            push(0, 4'hF, 32'h3000_0010 + 4 * i, 32'h0, 0);
        drain();

        // Consumer stalled: response held, no new strobe.
        rdy_mode = 0; dly_max = 2;
        push(1, 4'h3, 32'h3000_0020, 32'hDEAD_BEEF, 0);
        push(0, 4'hF, 32'h3000_0020, 32'h0, 0);
        seen = 0;
        for (int w = 0; w < 50 && !seen; w++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("hold_seen", seen, 1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_dat", rsp_dat, rspq[0].dat);
            chk("hold_no_cyc", wbm_cyc_o, 0);
        end
        rdy_mode = 1;
        drain();

        // Randomized traffic.
        rdy_mode = 2; dly_min = 0; dly_max = 3;
        for (int i = 0; i < 60; i++) begin
            push($urandom_range(0, 1), 4'($urandom_range(1, 15)),
                 32'h3000_0000 + 4 * $urandom_range(0, 7), $urandom, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 1;
        drain();

`ifdef WB_INIT_TIMEOUT_EN
        ack_en = 0;
        push(0, 4'hF, 32'h3000_0008, 32'h0, 1);
        n = 0;
        seen = 0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            seen = wbm_cyc_o;
        end
        while (wbm_cyc_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_len", n, TO);
        drain();
        ack_en = 1;
`endif

        // Reset during an active cycle, then a stray ack.
        ack_en = 0;
        push(0, 4'hF, 32'h3000_000C, 32'h0, 0);
        seen = 0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            seen = wbm_cyc_o;
        end
        chk("mid_req_seen", seen, 1);
        mon_en = 0;
        reset = 1;
        wbq.delete();
        rspq.delete();
        @(negedge clk);
        chk("mreset_cyc", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("mreset_rsp", rsp_valid, 0);
        chk("mreset_ready", cmd_ready, 1);
        reset = 0;
        force_ack = 1;
        @(negedge clk);
        force_ack = 0;
        chk("late_ack_cyc", wbm_cyc_o, 0);
        chk("late_ack_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("late_ack_rsp2", rsp_valid, 0);
        chk("late_ack_busy", busy, 0);
        ack_en = 1;
        mon_en = 1;

        push(0, 4'hF, 32'h3000_0004, 32'h0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
